// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath: MIPS funct codes, ALU select encodings,
// sequencer state encoding and small decode helpers.
package alu_pkg;

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;
    localparam logic [2:0] OP_NONE = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MULT = 2'b10,
        S_WB   = 2'b11
    } seq_state_t;

    function automatic logic [2:0] alu_op_of(input logic [5:0] f);
        case (f)
            F_AND:   return OP_AND;
            F_OR:    return OP_OR;
            F_ADD:   return OP_ADD;
            F_SUB:   return OP_SUB;
            F_SLT:   return OP_SLT;
            default: return OP_NONE;
        endcase
    endfunction

    // Codes that retire in a single EXEC cycle with a valid MUX result.
    function automatic logic is_single(input logic [5:0] f);
        case (f)
            F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MFHI, F_MFLO: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request handshake and datapath control bundle between a requester and the
// ALU sequencer.
interface alu_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] funct;
    logic [2:0] alu_op;
    logic       mult_start;
    logic       mult_step;
    logic       hilo_we;
    logic [5:0] out_sel;
    logic       out_valid;
    logic       done;
    logic       err;

    modport master (
        output req_valid, funct,
        input  req_ready, alu_op, mult_start, mult_step, hilo_we,
               out_sel, out_valid, done, err
    );

    modport slave (
        input  req_valid, funct,
        output req_ready, alu_op, mult_start, mult_step, hilo_we,
               out_sel, out_valid, done, err
    );
endinterface

// File: rtl/alu_seq_cnt.sv
// Multiplier step counter: counts 0..MULT_CYCLES-1 while enabled, flags the last
// step and wraps to 0 after it.
module alu_seq_cnt #(
    parameter  int MULT_CYCLES = 32,
    localparam int CNT_W       = $clog2(MULT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_cnt;

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == CNT_W'(MULT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || (i_en && o_tc)) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/alu_sequencer.sv
// Control FSM in front of the ALU datapath: accepts funct codes, sequences MULTU
// and HiLo write-back. ALU_SEQ_EARLY_ACCEPT_EN also accepts requests in EXEC.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MULT_CYCLES = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave sif
);
    localparam int CNT_W = $clog2(MULT_CYCLES + 1);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [5:0]       r_funct;
    logic             w_ready;
    logic             w_xfer;
    logic [CNT_W-1:0] w_cnt;
    logic             w_tc;
    logic [2:0]       w_alu_op;
    logic             w_mult_start;
    logic             w_mult_step;
    logic             w_hilo_we;
    logic [5:0]       w_out_sel;
    logic             w_out_valid;
    logic             w_done;
    logic             w_err;

    alu_seq_cnt #(.MULT_CYCLES(MULT_CYCLES)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (r_state != S_MULT),
        .i_en  (r_state == S_MULT),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    always_comb begin
        w_ready = (r_state == S_IDLE);
`ifdef ALU_SEQ_EARLY_ACCEPT_EN
        if (r_state == S_EXEC) w_ready = 1'b1;
`endif
    end

    assign w_xfer = sif.req_valid & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_funct <= '0;
        end else begin
            r_state <= w_next;
            if (w_xfer) r_funct <= sif.funct;
        end
    end

    // Outputs depend only on r_state/r_funct/counter; w_xfer only steers the next state.
    always_comb begin
        w_next       = r_state;
        w_alu_op     = OP_NONE;
        w_mult_start = 1'b0;
        w_mult_step  = 1'b0;
        w_hilo_we    = 1'b0;
        w_out_sel    = '0;
        w_out_valid  = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) w_next = (sif.funct == F_MULTU) ? S_MULT : S_EXEC;
            end
            S_EXEC: begin
                w_alu_op    = alu_op_of(r_funct);
                w_out_sel   = r_funct;
                w_out_valid = is_single(r_funct);
                w_err       = ~is_single(r_funct);
                w_done      = 1'b1;
                w_next      = S_IDLE;
                if (w_xfer) w_next = (sif.funct == F_MULTU) ? S_MULT : S_EXEC;
            end
            S_MULT: begin
                w_mult_step  = 1'b1;
                w_mult_start = (w_cnt == '0);
                if (w_tc) w_next = S_WB;
            end
            S_WB: begin
                w_hilo_we = 1'b1;
                w_done    = 1'b1;
                w_next    = S_IDLE;
            end
        endcase
    end

    assign sif.req_ready  = w_ready;
    assign sif.alu_op     = w_alu_op;
    assign sif.mult_start = w_mult_start;
    assign sif.mult_step  = w_mult_step;
    assign sif.hilo_we    = w_hilo_we;
    assign sif.out_sel    = w_out_sel;
    assign sif.out_valid  = w_out_valid;
    assign sif.done       = w_done;
    assign sif.err        = w_err;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: table-driven single-cycle ops, MULTU
// sequencing, held requests, unsupported codes and reset abort.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int MC = 32;
`ifdef ALU_SEQ_EARLY_ACCEPT_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if sif();

    alu_sequencer #(.MULT_CYCLES(MC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    typedef struct {
        logic [5:0] sel;
        logic [2:0] op;
        logic       vld;
        logic       err;
        logic       we;
        logic       chk_sel;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [5:0] f;
        logic [2:0] op;
        logic       vld;
        logic       err;
    } vec_t;

    exp_t q[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total = 0;
    int   hilo_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [5:0] sel, input logic [2:0] op, input logic vld,
                                input logic err, input logic we, input logic chk_sel);
        exp_t e;
        e.sel = sel; e.op = op; e.vld = vld; e.err = err; e.we = we; e.chk_sel = chk_sel;
        e.cyc = 0;
        return e;
    endfunction

    // Scoreboard: every retirement (done or hilo_we) must match the oldest accepted request.
    always @(negedge clk) begin : mon
        exp_t e;
        if (sif.hilo_we) hilo_seen++;
        if (rst_n && (sif.done || sif.hilo_we)) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_retire: done=%0b hilo_we=%0b at cycle %0d, required none",
                         sif.done, sif.hilo_we, cyc);
            end else begin
                e = q.pop_front();
                chk("retire_cycle", cyc, e.cyc);
                chk("done", 32'(sif.done), 32'd1);
                chk("hilo_we", 32'(sif.hilo_we), 32'(e.we));
                chk("alu_op", 32'(sif.alu_op), 32'(e.op));
                chk("out_valid", 32'(sif.out_valid), 32'(e.vld));
                chk("err", 32'(sif.err), 32'(e.err));
                if (e.chk_sel) chk("out_sel", 32'(sif.out_sel), 32'(e.sel));
            end
        end
    end

    // Call #1 after a posedge; returns #1 after the transfer edge.
    task automatic send(input logic [5:0] f, input exp_t e, output int tcyc);
        int n;
        n = 0;
        sif.req_valid = 1'b1;
        sif.funct     = f;
        while (!sif.req_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            total++;
            $display("FAIL send_timeout: funct %b never accepted, required acceptance", f);
            sif.req_valid = 1'b0;
            tcyc = -1;
            return;
        end
        @(posedge clk); #1;
        tcyc  = cyc;
        e.cyc = cyc + ((f == F_MULTU) ? MC : 0);
        q.push_back(e);
        sif.req_valid = 1'b0;
        sif.funct     = 6'b111111;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d retirements outstanding, required 0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    vec_t vecs[10];
    int   t1, t2, t3, starts, start_cyc, steps, ready_hi, h0;

    initial begin
        vecs[0] = '{F_ADD,     OP_ADD,  1'b1, 1'b0};
        vecs[1] = '{F_AND,     OP_AND,  1'b1, 1'b0};
        vecs[2] = '{F_OR,      OP_OR,   1'b1, 1'b0};
        vecs[3] = '{F_SUB,     OP_SUB,  1'b1, 1'b0};
        vecs[4] = '{F_SLT,     OP_SLT,  1'b1, 1'b0};
        vecs[5] = '{F_SLL,     OP_NONE, 1'b1, 1'b0};
        vecs[6] = '{F_MFHI,    OP_NONE, 1'b1, 1'b0};
        vecs[7] = '{F_MFLO,    OP_NONE, 1'b1, 1'b0};
        vecs[8] = '{6'b111111, OP_NONE, 1'b0, 1'b1};
        vecs[9] = '{6'b000001, OP_NONE, 1'b0, 1'b1};

        sif.req_valid = 1'b0;
        sif.funct     = 6'b000000;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(sif.req_ready), 32'd1);
        chk("rst_alu_op", 32'(sif.alu_op), 32'd0);
        chk("rst_out_sel", 32'(sif.out_sel), 32'd0);
        chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_done", 32'(sif.done), 32'd0);
        chk("rst_err", 32'(sif.err), 32'd0);
        chk("rst_mult_start", 32'(sif.mult_start), 32'd0);
        chk("rst_mult_step", 32'(sif.mult_step), 32'd0);
        chk("rst_hilo_we", 32'(sif.hilo_we), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle ops and unsupported codes
        for (int i = 0; i < 10; i++)
            send(vecs[i].f, mk(vecs[i].f, vecs[i].op, vecs[i].vld, vecs[i].err, 1'b0, 1'b1), t1);
        drain();

        // MULTU strobe sequencing
        send(F_MULTU, mk(6'd0, OP_NONE, 1'b0, 1'b0, 1'b1, 1'b0), t1);
        starts = 0; start_cyc = -1; steps = 0; ready_hi = 0;
        for (int k = 0; k <= MC; k++) begin
            @(negedge clk);
            if (sif.mult_start) begin starts++; start_cyc = cyc; end
            if (sif.mult_step) steps++;
            if (sif.req_ready) ready_hi++;
        end
        chk("mult_start_count", starts, 1);
        chk("mult_start_cycle", start_cyc, t1);
        chk("mult_step_count", steps, MC);
        chk("ready_low_in_mult_wb", ready_hi, 0);
        @(posedge clk); #1;
        drain();

        // MFHI held during MULTU is accepted only after WB
        send(F_MULTU, mk(6'd0, OP_NONE, 1'b0, 1'b0, 1'b1, 1'b0), t1);
        send(F_MFHI, mk(F_MFHI, OP_NONE, 1'b1, 1'b0, 1'b0, 1'b1), t2);
        chk("mfhi_accept_cycle", t2 - t1, MC + 2);
        drain();

        // Reset asserted at MULT step 10 aborts the multiply
        send(F_MULTU, mk(6'd0, OP_NONE, 1'b0, 1'b0, 1'b1, 1'b0), t1);
        repeat (11) @(negedge clk);
        chk("abort_at_step10", cyc - t1, 10);
        h0 = hilo_seen;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("abort_req_ready", 32'(sif.req_ready), 32'd1);
        chk("abort_mult_step", 32'(sif.mult_step), 32'd0);
        chk("abort_mult_start", 32'(sif.mult_start), 32'd0);
        chk("abort_done", 32'(sif.done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (MC + 5) @(posedge clk);
        #1;
        chk("abort_no_hilo_we", hilo_seen - h0, 0);
        send(F_SUB, mk(F_SUB, OP_SUB, 1'b1, 1'b0, 1'b0, 1'b1), t1);
        drain();

        // Back-to-back throughput
        send(F_AND, mk(F_AND, OP_AND, 1'b1, 1'b0, 1'b0, 1'b1), t1);
        send(F_OR,  mk(F_OR,  OP_OR,  1'b1, 1'b0, 1'b0, 1'b1), t2);
        send(F_SLT, mk(F_SLT, OP_SLT, 1'b1, 1'b0, 1'b0, 1'b1), t3);
        chk("throughput_gap1", t2 - t1, GAP);
        chk("throughput_gap2", t3 - t2, GAP);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", pass_cnt, total);
        $fatal(1);
    end
endmodule
